// File: rtl/program_mem.sv
// Program memory: loaded word-by-word over a valid/ready port, then read by the fetch port.
// Latency: fetch to instruction/fetch_valid is 1 cycle; a load write is visible to a fetch on the next cycle.
// Backpressure: load_ready is high only while loading; fetches are dropped unless mem_ready is high.
//
// Ports:
//   clk, rst_n          - sole clock; synchronous active-low reset
//   load_start          - begin a new program load at address 0 (beats any other request)
//   load_valid/data/last- load word stream; last word (or the top address) completes the load
//   load_ready          - high while the block is accepting load words
//   load_count          - number of words written by the current or most recent load
//   fetch_en/fetch_addr - fetch request from the program counter
//   instruction         - registered fetched word, held when no fetch is accepted
//   fetch_valid         - one-cycle pulse: instruction was updated by last cycle's fetch
//   mem_ready           - a complete program is present and fetches are accepted
//
// Build option: define PROG_MEM_BOOT_IMAGE_EN to preload a fixed boot image on reset
// and come out of reset READY; otherwise the memory is unreset and starts EMPTY.

module program_mem #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_start,
   input  logic              load_valid,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_last,
   output logic              load_ready,
   output logic [ADDR_W:0]   load_count,
   input  logic              fetch_en,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic [DATA_W-1:0] instruction,
   output logic              fetch_valid,
   output logic              mem_ready
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] PTR_MAX = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      LOAD  = 2'd1,
      READY = 2'd2
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] wr_ptr;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              wr_en;

`ifdef PROG_MEM_BOOT_IMAGE_EN
   // Boot image nibbles, address 0 in the most significant nibble.
   localparam logic [127:0] BOOT_IMG = 128'h0145_7536_8455_5366_8455_5536_6682_FFFF;
   localparam state_t       POST_RST = READY;

   function automatic logic [DATA_W-1:0] boot_word(input int a);
      logic [3:0] nib;
      if (a < 32) nib = BOOT_IMG[127 - 4*a -: 4];
      else        nib = 4'hF;
      return DATA_W'(nib);
   endfunction
`else
   localparam state_t       POST_RST = EMPTY;
`endif

   // A word lands only while loading, never under reset, and never in the
   // cycle that restarts the load.
   assign wr_en = rst_n && (state == LOAD) && load_valid && !load_start;

`ifdef PROG_MEM_BOOT_IMAGE_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= boot_word(i);
      end else if (wr_en) begin
         mem[wr_ptr] <= load_data;
      end
   end
`else
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= load_data;
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= POST_RST;
         mem_ready   <= (POST_RST == READY);
         load_ready  <= 1'b0;
         wr_ptr      <= '0;
         load_count  <= '0;
         instruction <= '0;
         fetch_valid <= 1'b0;
      end else begin
         fetch_valid <= 1'b0;
         if (load_start) begin
            state      <= LOAD;
            load_ready <= 1'b1;
            mem_ready  <= 1'b0;
            wr_ptr     <= '0;
            load_count <= '0;
         end else begin
            case (state)
               LOAD: begin
                  if (load_valid) begin
                     load_count <= load_count + CNT_ONE;
                     // The pointer stops at the top address so it never wraps;
                     // the top-address write also ends the load, which caps
                     // load_count at DEPTH.
                     if (wr_ptr != PTR_MAX) wr_ptr <= wr_ptr + PTR_ONE;
                     if (load_last || (wr_ptr == PTR_MAX)) begin
                        state      <= READY;
                        load_ready <= 1'b0;
                        mem_ready  <= 1'b1;
                     end
                  end
               end
               READY: begin
                  if (fetch_en) begin
                     instruction <= mem[fetch_addr];
                     fetch_valid <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_program_mem.sv
module tb_program_mem;
   localparam int AW = 5;
   localparam int DW = 4;
   localparam int DEPTH = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          load_start = 1'b0;
   logic          load_valid = 1'b0;
   logic [DW-1:0] load_data = '0;
   logic          load_last = 1'b0;
   logic          load_ready;
   logic [AW:0]   load_count;
   logic          fetch_en = 1'b0;
   logic [AW-1:0] fetch_addr = '0;
   logic [DW-1:0] instruction;
   logic          fetch_valid;
   logic          mem_ready;

   int checks = 0;
   int errors = 0;

   program_mem #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
      .load_last(load_last), .load_ready(load_ready), .load_count(load_count),
      .fetch_en(fetch_en), .fetch_addr(fetch_addr), .instruction(instruction),
      .fetch_valid(fetch_valid), .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      int seed;       // word i of the load is (seed + i) mod 16
      int n;          // words to send
      bit use_last;   // flag the final word with load_last
      int faddr;      // address fetched right after the load
      int exp_cnt;
      int exp_instr;
   } vec_t;
   vec_t vecs[4];

`ifdef PROG_MEM_BOOT_IMAGE_EN
   localparam bit BOOT = 1'b1;
   int boot_img[32] = '{0,1,4,5,7,5,3,6,8,4,5,5,5,3,6,6,8,4,5,5,5,5,3,6,6,6,8,2,15,15,15,15};
`else
   localparam bit BOOT = 1'b0;
`endif

   // Reference model: mode 0 = empty, 1 = loading, 2 = program present.
   int m_mode, m_cnt;
   int m_mem[DEPTH];
   bit m_known[DEPTH];
   int e_fv, e_instr;
   bit e_known;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      e_fv = 0; e_instr = 0; e_known = 1'b1; m_cnt = 0;
      for (int i = 0; i < DEPTH; i++) begin
`ifdef PROG_MEM_BOOT_IMAGE_EN
         m_mem[i] = boot_img[i]; m_known[i] = 1'b1;
`else
         m_mem[i] = 0; m_known[i] = 1'b0;
`endif
      end
      m_mode = BOOT ? 2 : 0;
   endtask

   task automatic do_fetch(input int addr, input int exp_fv, input int exp_instr, input string tag);
      fetch_en = 1'b1; fetch_addr = AW'(addr);
      tick();
      fetch_en = 1'b0;
      check({tag, "_fv"}, int'(fetch_valid), exp_fv);
      check({tag, "_instr"}, int'(instruction), exp_instr);
   endtask

   task automatic do_load(input int seed, input int n, input bit use_last);
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      check("load_rdy_in_load", int'(load_ready), 1);
      check("mem_rdy_in_load", int'(mem_ready), 0);
      for (int i = 0; i < n; i++) begin
         load_valid = 1'b1;
         load_data  = DW'((seed + i) % 16);
         load_last  = use_last && (i == n - 1);
         tick();
      end
      load_valid = 1'b0; load_last = 1'b0;
   endtask

   initial begin
      vecs[0] = '{10, 3, 1'b1, 2, 3, 12};
      vecs[1] = '{5, 1, 1'b1, 0, 1, 5};
      vecs[2] = '{3, 5, 1'b1, 4, 5, 7};
      vecs[3] = '{0, 32, 1'b0, 31, 32, 15};

      // Reset state
      tick();
      check("rst_instr", int'(instruction), 0);
      check("rst_fv", int'(fetch_valid), 0);
      check("rst_load_rdy", int'(load_ready), 0);
      check("rst_load_cnt", int'(load_count), 0);
      rst_n = 1'b1;
      tick();
      check("post_rst_mem_rdy", int'(mem_ready), BOOT ? 1 : 0);

      // Fetch straight out of reset
      if (BOOT) begin
         do_fetch(0, 1, 0, "boot0");
         do_fetch(4, 1, 7, "boot4");
         do_fetch(27, 1, 2, "boot27");
      end else begin
         do_fetch(0, 0, 0, "empty_fetch");
         check("empty_mem_rdy", int'(mem_ready), 0);
      end
      tick();
      check("fv_drops", int'(fetch_valid), 0);

      // Table of loads, each followed by a fetch the cycle after READY
      for (int v = 0; v < 4; v++) begin
         do_load(vecs[v].seed, vecs[v].n, vecs[v].use_last);
         check($sformatf("v%0d_mem_rdy", v), int'(mem_ready), 1);
         check($sformatf("v%0d_load_rdy", v), int'(load_ready), 0);
         check($sformatf("v%0d_cnt", v), int'(load_count), vecs[v].exp_cnt);
         do_fetch(vecs[v].faddr, 1, vecs[v].exp_instr, $sformatf("v%0d_fetch", v));
         tick();
         check($sformatf("v%0d_fv_clr", v), int'(fetch_valid), 0);
         check($sformatf("v%0d_hold", v), int'(instruction), vecs[v].exp_instr);
      end

      // 33rd word after a full load is ignored; address 0 keeps its word
      load_valid = 1'b1; load_data = 4'h9; load_last = 1'b1;
      tick();
      load_valid = 1'b0; load_last = 1'b0;
      check("full_cnt_sat", int'(load_count), 32);
      check("full_still_rdy", int'(mem_ready), 1);
      do_fetch(0, 1, 0, "full_addr0");

      // load_start beats a concurrent fetch and load word
      load_start = 1'b1; fetch_en = 1'b1; fetch_addr = '0;
      load_valid = 1'b1; load_data = 4'h3;
      tick();
      load_start = 1'b0; fetch_en = 1'b0;
      check("prio_fv", int'(fetch_valid), 0);
      check("prio_load_rdy", int'(load_ready), 1);
      check("prio_mem_rdy", int'(mem_ready), 0);
      check("prio_cnt", int'(load_count), 0);
      load_data = 4'h7; load_last = 1'b1;
      tick();
      load_valid = 1'b0; load_last = 1'b0;
      check("prio_cnt_after", int'(load_count), 1);
      do_fetch(0, 1, 7, "prio_word");

      // Reset in the middle of a load
      do_load(1, 2, 1'b0);
      rst_n = 1'b0; load_valid = 1'b1; load_data = 4'h9;
      tick();
      check("midrst_cnt", int'(load_count), 0);
      check("midrst_load_rdy", int'(load_ready), 0);
      check("midrst_fv", int'(fetch_valid), 0);
      check("midrst_instr", int'(instruction), 0);
      rst_n = 1'b1; load_valid = 1'b0;
      tick();
      check("midrst_mem_rdy", int'(mem_ready), BOOT ? 1 : 0);
      check("midrst_load_rdy2", int'(load_ready), 0);
      if (BOOT) do_fetch(4, 1, 7, "midrst_boot4");
      else      do_fetch(4, 0, 0, "midrst_reject");

      // Randomized traffic against the reference model
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      model_reset();
      for (int c = 0; c < 3000; c++) begin
         load_start = ($urandom_range(0, 39) == 0);
         load_valid = $urandom_range(0, 1);
         load_data  = DW'($urandom_range(0, 15));
         load_last  = ($urandom_range(0, 7) == 0);
         fetch_en   = $urandom_range(0, 1);
         fetch_addr = AW'($urandom_range(0, DEPTH - 1));
         e_fv = 0;
         if (load_start) begin
            m_mode = 1; m_cnt = 0;
         end else if (m_mode == 1 && load_valid) begin
            m_mem[m_cnt] = int'(load_data); m_known[m_cnt] = 1'b1;
            m_cnt++;
            if (load_last || m_cnt == DEPTH) m_mode = 2;
         end else if (m_mode == 2 && fetch_en) begin
            e_fv = 1; e_instr = m_mem[fetch_addr]; e_known = m_known[fetch_addr];
         end
         tick();
         check("rnd_fv", int'(fetch_valid), e_fv);
         check("rnd_mem_rdy", int'(mem_ready), (m_mode == 2) ? 1 : 0);
         check("rnd_load_rdy", int'(load_ready), (m_mode == 1) ? 1 : 0);
         check("rnd_cnt", int'(load_count), m_cnt);
         if (e_known) check("rnd_instr", int'(instruction), e_instr);
      end
      load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0; fetch_en = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/program_mem.md
PROGRAM_MEM -- requirements
Module: program_mem

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, program address width; DEPTH = 2**ADDR_W.
REQ-002 SHALL have parameter DATA_W, default 4, instruction width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous active-low reset, sampled on clk rising edge.
REQ-005 SHALL have port load_start  input  1  pulse that begins a program load at address 0.
REQ-006 SHALL have port load_valid  input  1  load_data holds a word to write.
REQ-007 SHALL have port load_data  input  DATA_W  instruction word to write.
REQ-008 SHALL have port load_last  input  1  marks final word of the load, qualified by load_valid.
REQ-009 SHALL have port load_ready  output  1  block accepts a load word this cycle.
REQ-010 SHALL have port load_count  output  ADDR_W+1  words written in the current or most recent load.
REQ-011 SHALL have port fetch_en  input  1  fetch request for fetch_addr.
REQ-012 SHALL have port fetch_addr  input  ADDR_W  address from the program counter.
REQ-013 SHALL have port instruction  output  DATA_W  registered fetched instruction.
REQ-014 SHALL have port fetch_valid  output  1  instruction updated by a fetch accepted last cycle.
REQ-015 SHALL have port mem_ready  output  1  memory holds a valid program and accepts fetches.

Function
REQ-016 SHALL implement FSM states EMPTY, LOAD, READY; mem_ready = 1 only in READY; load_ready = 1 only in LOAD.
REQ-017 SHALL, on load_start in any state, enter LOAD next cycle, clearing the write pointer and load_count to 0.
REQ-018 SHALL, in LOAD, write load_data to mem[pointer] when load_valid is high, then increment pointer and load_count.
REQ-019 SHALL leave LOAD for READY after the write where load_last = 1 or the pointer = DEPTH-1, whichever comes first; the pointer does not wrap.
REQ-020 SHALL ignore load_valid, load_data and load_last outside LOAD, and in the same cycle as load_start.
REQ-021 SHALL give load_start priority over a concurrent load_valid or fetch_en.
REQ-022 SHALL, in READY with fetch_en = 1, register mem[fetch_addr] into instruction and assert fetch_valid for exactly the next cycle (latency 1).
REQ-023 SHALL, when a fetch is not accepted, drive fetch_valid = 0 next cycle and hold instruction at its last value.
REQ-024 SHALL return the newly written word for a fetch issued in the cycle after the READY transition.
REQ-025 SHALL saturate load_count at DEPTH and hold it in READY until the next load_start.

Reset
REQ-026 SHALL, when rst_n = 0 at a clk edge, clear instruction, fetch_valid, load_ready, load_count and the write pointer to 0, overriding every other input.
REQ-027 SHALL, on reset mid-load, abandon the load with no further writes; contents already written are not guaranteed to be retained.
REQ-028 SHALL enter its post-reset state (see Configuration) on the first clk edge with rst_n = 1.

Configuration
REQ-029 SHALL honour macro PROG_MEM_BOOT_IMAGE_EN.
REQ-030 SHALL, with PROG_MEM_BOOT_IMAGE_EN defined, load the boot image into mem on reset and enter READY.
- Boot image, addresses 0..31: 0,1,4,5,7,5,3,6,8,4,5,5,5,3,6,6,8,4,5,5,5,5,3,6,6,6,8,2,F,F,F,F (hex).
- Addresses 32 and above: F.
- Each entry truncated or zero-extended to DATA_W.
REQ-031 SHALL, without PROG_MEM_BOOT_IMAGE_EN, leave mem contents unreset and enter EMPTY, rejecting fetches until a load completes.

Verification
REQ-032 SHALL pass: boot-image build, reset then fetch addresses 0, 4, 27 -> instruction 0x0, 0x7, 0x2 one cycle after each, fetch_valid pulses.
REQ-033 SHALL pass: non-boot build, reset, fetch_en=1 at addr 0 -> fetch_valid stays 0, mem_ready=0, instruction=0.
REQ-034 SHALL pass: load_start, then 3 words A,B,C with load_last on C -> READY after C, load_count=3, fetch addr 2 -> 0xC.
REQ-035 SHALL pass: load of DEPTH=32 words with no load_last -> READY after the 32nd word, load_count=32, 33rd load_valid ignored.
REQ-036 SHALL pass: load_start and fetch_en in the same cycle while READY -> fetch rejected, fetch_valid=0, state LOAD.
REQ-037 SHALL pass: rst_n low mid-load after 2 words -> outputs 0 next cycle; boot build READY with image, non-boot build EMPTY.
